// File: rtl/sort_pkg.sv
// Shared definitions for the sorting chain: key field bounds, cell state flags and
// the drain reader FSM encoding.
package sort_pkg;

    localparam int unsigned PRIO_HI = 19;
    localparam int unsigned PRIO_LO = 12;
    localparam int unsigned TIE_HI  = 11;
    localparam int unsigned TIE_LO  = 0;
    localparam int unsigned KEY_W   = PRIO_HI - TIE_LO + 1;

    localparam logic EMPTY    = 1'b0;
    localparam logic OCCUPIED = 1'b1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLoad  = 2'd1,
        StDrain = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/sort_key_cmp.sv
// Unsigned key comparator: priority field first, tiebreak field on equal priority.
module sort_key_cmp
    import sort_pkg::*;
(
    input  logic [KEY_W-1:0] a,
    input  logic [KEY_W-1:0] b,
    output logic             a_gt_b
);

    logic prio_gt;
    logic prio_eq;
    logic tie_gt;

    assign prio_gt = a[PRIO_HI:PRIO_LO] >  b[PRIO_HI:PRIO_LO];
    assign prio_eq = a[PRIO_HI:PRIO_LO] == b[PRIO_HI:PRIO_LO];
    assign tie_gt  = a[TIE_HI:TIE_LO]   >  b[TIE_HI:TIE_LO];

    assign a_gt_b = prio_gt || (prio_eq && tie_gt);

endmodule

// File: rtl/sort_drain_reader.sv
// Freezes the sorting chain, snapshots its occupied head cells and drains them in order
// over a valid/ready stream, flagging any popped key that rises above its predecessor.
module sort_drain_reader
    import sort_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [DEPTH*WIDTH-1:0]       snap_data,
    input  logic [DEPTH-1:0]             snap_state,
    output logic                         sorter_en,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic [$clog2(DEPTH+1)-1:0]   remaining,
    output logic                         busy,
    output logic                         done,
    output logic                         order_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   buf_q [DEPTH];
    logic [WIDTH-1:0]   buf_d [DEPTH];
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [CNT_W-1:0]   load_cnt;
    logic               load_stop;
    logic [KEY_W-1:0]   prev_key_q, prev_key_d;
    logic               first_q, first_d;
    logic               order_err_q, order_err_d;
    logic               head_gt_prev;

    sort_key_cmp u_key_cmp (
        .a      (buf_q[0][KEY_W-1:0]),
        .b      (prev_key_q),
        .a_gt_b (head_gt_prev)
    );

    // Only the contiguous run of occupied cells from the head counts.
    always_comb begin
        load_cnt  = '0;
        load_stop = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!load_stop && snap_state[i] == OCCUPIED) begin
                load_cnt = CNT_W'(i + 1);
            end else begin
                load_stop = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        buf_d       = buf_q;
        remaining_d = remaining_q;
        prev_key_d  = prev_key_q;
        first_d     = first_q;
        order_err_d = order_err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d     = StLoad;
                    order_err_d = 1'b0;
                end
            end
            StLoad: begin
                for (int i = 0; i < int'(DEPTH); i++) begin
                    buf_d[i] = snap_data[i*WIDTH +: WIDTH];
                end
                remaining_d = load_cnt;
                first_d     = 1'b1;
                state_d     = (load_cnt == '0) ? StDone : StDrain;
            end
            StDrain: begin
                if (out_ready) begin
                    for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                        buf_d[i] = buf_q[i+1];
                    end
                    buf_d[DEPTH-1] = '0;
                    remaining_d    = remaining_q - 1'b1;
                    prev_key_d     = buf_q[0][KEY_W-1:0];
                    first_d        = 1'b0;
                    if (!first_q && head_gt_prev) begin
                        order_err_d = 1'b1;
                    end
                    if (remaining_q == CNT_W'(1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            for (int i = 0; i < int'(DEPTH); i++) begin
                buf_q[i] <= '0;
            end
            remaining_q <= '0;
            prev_key_q  <= '0;
            first_q     <= 1'b1;
            order_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            remaining_q <= remaining_d;
            prev_key_q  <= prev_key_d;
            first_q     <= first_d;
            order_err_q <= order_err_d;
        end
    end

    assign sorter_en = (state_q == StIdle);
    assign busy      = (state_q != StIdle);
    assign out_valid = (state_q == StDrain);
    assign out_last  = (state_q == StDrain) && (remaining_q == CNT_W'(1));
    assign done      = (state_q == StDone);
    assign out_data  = buf_q[0];
    assign remaining = remaining_q;
    assign order_err = order_err_q;

endmodule

// File: tb/tb_sort_drain_reader.sv
// Bench for sort_drain_reader: directed drains plus randomized snapshots and back-pressure,
// checked against a queue-based reference model.
module tb_sort_drain_reader;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic [DEPTH*WIDTH-1:0]   snap_data;
    logic [DEPTH-1:0]         snap_state;
    logic                     sorter_en;
    logic [WIDTH-1:0]         out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic [CNT_W-1:0]         remaining;
    logic                     busy;
    logic                     done;
    logic                     order_err;

    int n_cmp = 0;
    int n_err = 0;

    sort_drain_reader #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .snap_data  (snap_data),
        .snap_state (snap_state),
        .sorter_en  (sorter_en),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .remaining  (remaining),
        .busy       (busy),
        .done       (done),
        .order_err  (order_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // mode 0: ready always high; 1: random ready; 2: ready low for 3 cycles on the first beat
    task automatic do_drain(input logic [DEPTH-1:0] st, input logic [DEPTH*WIDTH-1:0] dat,
                            input int mode, input string tag);
        logic [WIDTH-1:0] q[$];
        int               n;
        int               cyc;
        int               stall;
        logic             rdy;
        logic [19:0]      prev;
        bit               have_prev;
        bit               err;

        n = 0;
        while (n < int'(DEPTH) && st[n]) n++;
        for (int i = 0; i < n; i++) q.push_back(dat[i*WIDTH +: WIDTH]);

        snap_state = st;
        snap_data  = dat;
        out_ready  = 1'b0;
        start      = 1'b1;
        step();
        start = 1'b0;
        chk({tag, " load busy"}, busy, 1);
        chk({tag, " load sorter_en"}, sorter_en, 0);
        chk({tag, " load out_valid"}, out_valid, 0);
        chk({tag, " load order_err clear"}, order_err, 0);
        step();

        cyc = 0; stall = 0; have_prev = 0; err = 0; prev = '0;
        while (q.size() > 0) begin
            if (cyc > 200) begin
                chk({tag, " drain timeout"}, 0, 1);
                break;
            end
            chk({tag, " out_valid"}, out_valid, 1);
            chk({tag, " out_data"}, out_data, q[0]);
            chk({tag, " out_last"}, out_last, (q.size() == 1));
            chk({tag, " remaining"}, remaining, q.size());
            chk({tag, " sorter_en drain"}, sorter_en, 0);
            chk({tag, " done drain"}, done, 0);
            if (mode == 0) rdy = 1'b1;
            else if (mode == 2) begin
                if (q.size() == n && stall < 3) begin
                    rdy = 1'b0;
                    stall++;
                end else rdy = 1'b1;
            end else rdy = 1'($urandom_range(0, 1));
            out_ready = rdy;
            start     = 1'($urandom_range(0, 1));
            step();
            if (rdy) begin
                if (have_prev && q[0][19:0] > prev) err = 1;
                prev      = q[0][19:0];
                have_prev = 1;
                void'(q.pop_front());
            end
            chk({tag, " order_err"}, order_err, err);
            cyc++;
        end
        start     = 1'b0;
        out_ready = 1'b0;
        chk({tag, " done pulse"}, done, 1);
        chk({tag, " done out_valid"}, out_valid, 0);
        chk({tag, " done busy"}, busy, 1);
        chk({tag, " done sorter_en"}, sorter_en, 0);
        step();
        chk({tag, " idle busy"}, busy, 0);
        chk({tag, " idle done"}, done, 0);
        chk({tag, " idle sorter_en"}, sorter_en, 1);
        chk({tag, " idle out_valid"}, out_valid, 0);
        chk({tag, " idle order_err held"}, order_err, err);
    endtask

    initial begin
        logic [DEPTH*WIDTH-1:0] dat;
        logic [DEPTH-1:0]       st;
        logic [WIDTH-1:0]       w;

        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        snap_state = '0; snap_data = '0;
        step();
        step();
        chk("reset out_valid", out_valid, 0);
        chk("reset out_last", out_last, 0);
        chk("reset done", done, 0);
        chk("reset busy", busy, 0);
        chk("reset out_data", out_data, 0);
        chk("reset sorter_en", sorter_en, 1);
        chk("reset remaining", remaining, 0);
        chk("reset order_err", order_err, 0);
        rst = 1'b0;
        step();

        // Three ordered keys; upper bits carry pass-through payload.
        dat = '0;
        dat[0*WIDTH +: WIDTH] = 32'hA5A50001;
        dat[1*WIDTH +: WIDTH] = 32'h12340002;
        dat[2*WIDTH +: WIDTH] = 32'hFFF40001;
        do_drain(8'b0000_0111, dat, 0, "three");

        do_drain(8'b0000_0000, dat, 0, "empty");

        dat = '0;
        dat[0*WIDTH +: WIDTH] = 32'h00060010;
        dat[1*WIDTH +: WIDTH] = 32'h00050020;
        do_drain(8'b0000_0011, dat, 2, "stall");

        dat = '0;
        dat[0*WIDTH +: WIDTH] = 32'h00030000;
        dat[1*WIDTH +: WIDTH] = 32'h00031000;
        do_drain(8'b0000_0011, dat, 0, "order");

        dat = '0;
        for (int i = 0; i < int'(DEPTH); i++) dat[i*WIDTH +: WIDTH] = 32'h00090000 - i;
        do_drain(8'b0000_1011, dat, 0, "gap");

        // Reset mid-drain with five entries pending.
        snap_state = 8'b0001_1111;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        out_ready = 1'b0;
        start = 1'b1;
        step();
        chk("rstmid still draining", out_valid, 1);
        chk("rstmid remaining", remaining, 5);
        start = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid busy", busy, 0);
        chk("rstmid out_valid", out_valid, 0);
        chk("rstmid sorter_en", sorter_en, 1);
        chk("rstmid remaining", remaining, 0);
        chk("rstmid out_data", out_data, 0);
        step();

        for (int r = 0; r < 20; r++) begin
            dat = '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                w = $urandom();
                w[19:12] = 8'h30 + 8'($urandom_range(0, 3));
                w[11:0]  = 12'($urandom_range(0, 2));
                dat[i*WIDTH +: WIDTH] = w;
            end
            if (r % 2 == 0) st = 8'hFF >> $urandom_range(0, 8);
            else st = 8'($urandom());
            do_drain(st, dat, 1, "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
